// File: rtl/cpu_pkg.sv
// Shared types and constants for the ALU control unit: FSM states, instruction classes,
// ALU opcodes and instruction field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StOut,
        StHalt
    } state_e;

    localparam logic [1:0] ClsAlu  = 2'b00;
    localparam logic [1:0] ClsLdi  = 2'b01;
    localparam logic [1:0] ClsOut  = 2'b10;
    localparam logic [1:0] ClsHalt = 2'b11;

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpSub = 2'b01;
    localparam logic [1:0] OpAnd = 2'b10;
    localparam logic [1:0] OpOr  = 2'b11;

    localparam int unsigned InstrWidth = 16;
    localparam int unsigned ClsLsb     = 14;
    localparam int unsigned OpLsb      = 12;
    localparam int unsigned RdLsb      = 10;
    localparam int unsigned Rs1Lsb     = 8;
    localparam int unsigned Rs2Lsb     = 6;

    function automatic logic [1:0] get_field(input logic [InstrWidth-1:0] word,
                                             input int unsigned lsb);
        return word[lsb +: 2];
    endfunction

endpackage

// File: rtl/alu_control_unit_if.sv
// Bus bundle between the control unit (master) and its instruction memory, ALU and
// result consumer (slave).
interface alu_control_unit_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] pc;
    logic                  instr_req;
    logic                  instr_valid;
    logic [15:0]           instr_data;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [1:0]            alu_opcode;
    logic                  alu_enable;
    logic [DATA_WIDTH-1:0] alu_out;
    logic                  alu_zero;
    logic                  alu_overflow;
    logic                  res_valid;
    logic                  res_ready;
    logic [DATA_WIDTH-1:0] res_data;

    modport master (
        output pc, instr_req, alu_a, alu_b, alu_opcode, alu_enable, res_valid, res_data,
        input  instr_valid, instr_data, alu_out, alu_zero, alu_overflow, res_ready
    );

    modport slave (
        input  pc, instr_req, alu_a, alu_b, alu_opcode, alu_enable, res_valid, res_data,
        output instr_valid, instr_data, alu_out, alu_zero, alu_overflow, res_ready
    );

endinterface

// File: rtl/reg_file.sv
// 4-entry register file: two asynchronous read ports, one synchronous write port,
// synchronous active-high reset to zero.
module reg_file #(
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [1:0]           waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [1:0]           raddr_a_i,
    input  logic [1:0]           raddr_b_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o
);
    logic [DataWidth-1:0] regs_q [4];
    logic [DataWidth-1:0] regs_d [4];

    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_control_unit.sv
// Fetch/decode/execute sequencer driving an external 8-bit ALU, with a 4-entry register
// file and a valid/ready result export port.
module alu_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_control_unit_if.master  bus,
    output logic                zero_q,
    output logic                ovf_q,
    output logic                halted
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic                  zero_flag_q, zero_flag_d;
    logic                  ovf_flag_q, ovf_flag_d;
    logic                  res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;

    logic [1:0]            cls, op, rd, rs1, rs2;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_wdata, rdata_a, rdata_b;

    assign cls = get_field(ir_q, ClsLsb);
    assign op  = get_field(ir_q, OpLsb);
    assign rd  = get_field(ir_q, RdLsb);
    assign rs1 = get_field(ir_q, Rs1Lsb);
    assign rs2 = get_field(ir_q, Rs2Lsb);

    reg_file #(
        .DataWidth(DATA_WIDTH)
    ) u_reg_file (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (rf_we),
        .waddr_i   (rd),
        .wdata_i   (rf_wdata),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            ir_q        <= '0;
            zero_flag_q <= 1'b0;
            ovf_flag_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            zero_flag_q <= zero_flag_d;
            ovf_flag_q  <= ovf_flag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (bus.instr_valid) state_d = StDecode;
            StDecode: begin
                unique case (cls)
                    ClsAlu:  state_d = StExec;
                    ClsLdi:  state_d = StFetch;
                    ClsOut:  state_d = StOut;
                    ClsHalt: state_d = StHalt;
                endcase
            end
            StExec:   state_d = StFetch;
            StOut:    if (bus.res_ready) state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    // Datapath updates: IR latch, register writes, flags, pc advance and result port.
    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        zero_flag_d = zero_flag_q;
        ovf_flag_d  = ovf_flag_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        rf_we       = 1'b0;
        rf_wdata    = bus.alu_out;
        unique case (state_q)
            StFetch: if (bus.instr_valid) ir_d = bus.instr_data;
            StDecode: begin
                if (cls == ClsLdi) begin
                    rf_we    = 1'b1;
                    rf_wdata = ir_q[DATA_WIDTH-1:0];
                    pc_d     = pc_q + 1'b1;
                end else if (cls == ClsOut) begin
                    res_data_d  = rdata_a;
                    res_valid_d = 1'b1;
                end
            end
            StExec: begin
                rf_we       = 1'b1;
                zero_flag_d = bus.alu_zero;
                ovf_flag_d  = bus.alu_overflow;
                pc_d        = pc_q + 1'b1;
            end
            StOut: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    pc_d        = pc_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.pc         = pc_q;
        bus.instr_req  = (state_q == StFetch);
        bus.alu_enable = (state_q == StExec);
        bus.alu_a      = (state_q == StExec) ? rdata_a : '0;
        bus.alu_b      = (state_q == StExec) ? rdata_b : '0;
        bus.alu_opcode = (state_q == StExec) ? op : 2'b00;
        bus.res_valid  = res_valid_q;
        bus.res_data   = res_data_q;
        zero_q         = zero_flag_q;
        ovf_q          = ovf_flag_q;
        halted         = (state_q == StHalt);
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit with a behavioural ALU and instruction memory.
module tb_alu_control_unit;
    import cpu_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst;
    logic zero_q, ovf_q, halted;
    logic fetch_en;

    always #5 clk = ~clk;

    alu_control_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    alu_control_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .zero_q (zero_q),
        .ovf_q  (ovf_q),
        .halted (halted)
    );

    logic [15:0] imem [256];
    logic [DW:0] alu_sum;
    logic [9:0]  exp_q [$];
    logic [9:0]  mon_e;
    int          n_total = 0;
    int          n_bad   = 0;
    int          n_xfer  = 0;

    always_comb begin
        alu_sum = '0;
        case (bus.alu_opcode)
            OpAdd: alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            OpSub: alu_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            OpAnd: alu_sum = {1'b0, bus.alu_a & bus.alu_b};
            OpOr:  alu_sum = {1'b0, bus.alu_a | bus.alu_b};
            default: alu_sum = '0;
        endcase
    end

    assign bus.alu_out      = alu_sum[DW-1:0];
    assign bus.alu_zero     = (alu_sum[DW-1:0] == '0);
    assign bus.alu_overflow = alu_sum[DW];
    assign bus.instr_valid  = bus.instr_req & fetch_en;
    assign bus.instr_data   = imem[bus.pc];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {ClsLdi, 2'b00, rd, 2'b00, imm};
    endfunction

    function automatic logic [15:0] enc_alu(input logic [1:0] op, input logic [1:0] rd,
                                            input logic [1:0] rs1, input logic [1:0] rs2);
        return {ClsAlu, op, rd, rs1, rs2, 6'b000000};
    endfunction

    function automatic logic [15:0] enc_out(input logic [1:0] rs1);
        return {ClsOut, 2'b00, 2'b00, rs1, 8'h00};
    endfunction

    function automatic logic [15:0] enc_halt();
        return {ClsHalt, 14'h0000};
    endfunction

    // Result monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("res_extra", {31'd0, bus.res_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("res_data", {24'd0, bus.res_data}, {24'd0, mon_e[9:2]});
                check("res_zero", {31'd0, zero_q}, {31'd0, mon_e[1]});
                check("res_ovf", {31'd0, ovf_q}, {31'd0, mon_e[0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = enc_halt();
    endtask

    task automatic wait_halt(input int max);
        for (int i = 0; i < max && !halted; i++) tick();
    endtask

    task automatic wait_res_valid(input int max);
        for (int i = 0; i < max && !bus.res_valid; i++) tick();
    endtask

    task automatic wait_alu_en(input int max);
        for (int i = 0; i < max && !bus.alu_enable; i++) tick();
    endtask

    task automatic wait_pc(input logic [7:0] v, input int max);
        for (int i = 0; i < max && bus.pc !== v; i++) tick();
    endtask

    task automatic wait_pc_not(input logic [7:0] v, input int max);
        for (int i = 0; i < max && bus.pc === v; i++) tick();
    endtask

    initial begin
        rst           = 1'b1;
        fetch_en      = 1'b1;
        bus.res_ready = 1'b1;

        // Program 1: arithmetic, flags, flag retention across LDI, rd==rs1.
        clear_imem();
        imem[0]  = enc_ldi(2'd1, 8'h05);
        imem[1]  = enc_ldi(2'd2, 8'h03);
        imem[2]  = enc_alu(OpAdd, 2'd3, 2'd1, 2'd2);
        imem[3]  = enc_out(2'd3);
        imem[4]  = enc_ldi(2'd1, 8'hFF);
        imem[5]  = enc_ldi(2'd2, 8'h01);
        imem[6]  = enc_alu(OpAdd, 2'd0, 2'd1, 2'd2);
        imem[7]  = enc_out(2'd0);
        imem[8]  = enc_ldi(2'd3, 8'h55);
        imem[9]  = enc_out(2'd3);
        imem[10] = enc_ldi(2'd1, 8'h02);
        imem[11] = enc_ldi(2'd2, 8'h03);
        imem[12] = enc_alu(OpSub, 2'd0, 2'd1, 2'd2);
        imem[13] = enc_out(2'd0);
        imem[14] = enc_ldi(2'd1, 8'hF0);
        imem[15] = enc_ldi(2'd2, 8'h0F);
        imem[16] = enc_alu(OpAnd, 2'd0, 2'd1, 2'd2);
        imem[17] = enc_out(2'd0);
        imem[18] = enc_alu(OpOr, 2'd3, 2'd1, 2'd2);
        imem[19] = enc_out(2'd3);
        imem[20] = enc_alu(OpAdd, 2'd1, 2'd1, 2'd1);
        imem[21] = enc_out(2'd1);
        exp_q.push_back({8'h08, 1'b0, 1'b0});
        exp_q.push_back({8'h00, 1'b1, 1'b1});
        exp_q.push_back({8'h55, 1'b1, 1'b1});
        exp_q.push_back({8'hFF, 1'b0, 1'b1});
        exp_q.push_back({8'h00, 1'b1, 1'b0});
        exp_q.push_back({8'hFF, 1'b0, 1'b0});
        exp_q.push_back({8'hE0, 1'b0, 1'b1});

        tick();
        tick();
        check("rst_pc", {24'd0, bus.pc}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_data", {24'd0, bus.res_data}, 32'd0);
        check("rst_alu_en", {31'd0, bus.alu_enable}, 32'd0);
        check("rst_alu_a", {24'd0, bus.alu_a}, 32'd0);
        check("rst_alu_b", {24'd0, bus.alu_b}, 32'd0);
        check("rst_alu_op", {30'd0, bus.alu_opcode}, 32'd0);
        check("rst_zero", {31'd0, zero_q}, 32'd0);
        check("rst_ovf", {31'd0, ovf_q}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_req", {31'd0, bus.instr_req}, 32'd1);
        rst = 1'b0;

        wait_alu_en(20);
        check("exec_en", {31'd0, bus.alu_enable}, 32'd1);
        check("exec_a", {24'd0, bus.alu_a}, 32'h05);
        check("exec_b", {24'd0, bus.alu_b}, 32'h03);
        check("exec_op", {30'd0, bus.alu_opcode}, {30'd0, OpAdd});
        check("exec_pc", {24'd0, bus.pc}, 32'd2);

        wait_halt(400);
        check("p1_halted", {31'd0, halted}, 32'd1);
        check("p1_req", {31'd0, bus.instr_req}, 32'd0);
        check("p1_pc", {24'd0, bus.pc}, 32'd22);
        check("p1_pending", exp_q.size(), 32'd0);
        check("p1_xfers", n_xfer, 32'd7);
        repeat (3) tick();
        check("p1_pc_hold", {24'd0, bus.pc}, 32'd22);

        // Program 2: OUT stalled for five cycles, then a single transfer.
        rst = 1'b1;
        clear_imem();
        imem[0] = enc_ldi(2'd2, 8'hA5);
        imem[1] = enc_out(2'd2);
        bus.res_ready = 1'b0;
        tick();
        check("p2_rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        n_xfer = 0;
        wait_res_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, bus.res_valid}, 32'd1);
            check("stall_data", {24'd0, bus.res_data}, 32'hA5);
            check("stall_pc", {24'd0, bus.pc}, 32'd1);
            tick();
        end
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("post_valid", {31'd0, bus.res_valid}, 32'd0);
        check("post_pc", {24'd0, bus.pc}, 32'd2);
        wait_halt(20);
        check("p2_xfers", n_xfer, 32'd1);
        check("p2_pc", {24'd0, bus.pc}, 32'd2);

        // Program 3: reset during an OUT stall clears regs, flags and the result port.
        rst = 1'b1;
        clear_imem();
        imem[0] = enc_ldi(2'd1, 8'hFF);
        imem[1] = enc_ldi(2'd2, 8'h01);
        imem[2] = enc_alu(OpAdd, 2'd0, 2'd1, 2'd2);
        imem[3] = enc_ldi(2'd2, 8'hA5);
        imem[4] = enc_out(2'd2);
        tick();
        rst = 1'b0;
        wait_res_valid(30);
        check("p3_valid", {31'd0, bus.res_valid}, 32'd1);
        check("p3_zero", {31'd0, zero_q}, 32'd1);
        check("p3_pc", {24'd0, bus.pc}, 32'd4);
        rst = 1'b1;
        tick();
        check("p3_rst_pc", {24'd0, bus.pc}, 32'd0);
        check("p3_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        check("p3_rst_zero", {31'd0, zero_q}, 32'd0);
        check("p3_rst_ovf", {31'd0, ovf_q}, 32'd0);
        clear_imem();
        for (int i = 0; i < 4; i++) begin
            imem[i] = enc_out(2'(i));
            exp_q.push_back({8'h00, 1'b0, 1'b0});
        end
        bus.res_ready = 1'b1;
        n_xfer = 0;
        rst = 1'b0;
        wait_halt(60);
        check("p3_xfers", n_xfer, 32'd4);
        check("p3_pending", exp_q.size(), 32'd0);
        check("p3_halt_pc", {24'd0, bus.pc}, 32'd4);

        // Program 4: reset mid-fetch, then a straight LDI run that wraps the pc.
        rst = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = enc_ldi(2'd0, 8'(i));
        tick();
        rst = 1'b0;
        wait_pc(8'd3, 30);
        check("p4_pc3", {24'd0, bus.pc}, 32'd3);
        check("p4_fetch_valid", {31'd0, bus.instr_valid}, 32'd1);
        rst = 1'b1;
        tick();
        check("p4_rst_pc", {24'd0, bus.pc}, 32'd0);
        check("p4_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        rst = 1'b0;
        wait_pc(8'hFF, 600);
        check("wrap_at_ff", {24'd0, bus.pc}, 32'hFF);
        wait_pc_not(8'hFF, 10);
        check("wrap_to_0", {24'd0, bus.pc}, 32'h00);

        // Program 5: HALT at the last address does not wrap.
        rst = 1'b1;
        imem[255] = enc_halt();
        tick();
        rst = 1'b0;
        wait_halt(600);
        check("p5_halted", {31'd0, halted}, 32'd1);
        check("p5_pc", {24'd0, bus.pc}, 32'hFF);
        check("p5_req", {31'd0, bus.instr_req}, 32'd0);
        repeat (4) tick();
        check("p5_pc_hold", {24'd0, bus.pc}, 32'hFF);
        check("p5_halt_hold", {31'd0, halted}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
